// File: rtl/pc_fetch_sequencer_pkg.sv
// Shared types, defaults and the PC address mask used by the fetch sequencer
// and by any branch-target adder that must produce the same aligned address.
package pc_fetch_sequencer_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_t;

  localparam int unsigned ADDR_BITS_DEF  = 20;
  localparam logic [31:0] RESET_PC_DEF   = 32'h0000_0000;
  localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_0180;

  // Widest PC the mask helper supports; callers cast down to their own width.
  localparam int unsigned PC_MAX_W = 64;

  // Keeps bits [addr_bits-1:2] and clears everything else (word aligned).
  function automatic logic [PC_MAX_W-1:0] pc_mask(input logic [PC_MAX_W-1:0] value,
                                                  input int unsigned         addr_bits);
    logic [PC_MAX_W-1:0] keep;
    keep      = (PC_MAX_W'(1) << addr_bits) - PC_MAX_W'(1);
    keep[1:0] = 2'b00;
    return value & keep;
  endfunction

endpackage

// File: rtl/pc_fetch_sequencer_mux.sv
// Next-PC selection: redirect priority (exception > branch > jump) over
// sequential advance, with every loaded value forced into the implemented range.
module pc_next_mux
  import pc_fetch_sequencer_pkg::*;
#(
  parameter int unsigned N          = 32,
  parameter int unsigned ADDR_BITS  = ADDR_BITS_DEF,
  parameter logic [N-1:0] EXC_VECTOR = N'(EXC_VECTOR_DEF)
) (
  input  fetch_state_t   state,
  input  logic [N-1:0]   pc,
  input  logic           advance,
  input  logic           exception,
  input  logic           branch_taken,
  input  logic [N-1:0]   branch_target,
  input  logic           jump,
  input  logic [N-1:0]   jump_target,
  output logic [N-1:0]   pc_next,
  output logic [N-1:0]   pc_plus4,
  output logic           redirect
);

  function automatic logic [N-1:0] mask_n(input logic [N-1:0] value);
    return N'(pc_mask(PC_MAX_W'(value), ADDR_BITS));
  endfunction

  logic [N-1:0] target;

  // Redirect sources are only honoured once the sequencer has left BOOT.
  assign redirect = (state != BOOT) && (exception || branch_taken || jump);
  assign target   = exception    ? EXC_VECTOR    :
                    branch_taken ? branch_target : jump_target;
  assign pc_plus4 = mask_n(pc + N'(4));

  always_comb begin
    pc_next = pc;
    if (redirect) begin
      pc_next = mask_n(target);
    end else if (advance) begin
      pc_next = pc_plus4;
    end
  end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Fetch-stage controller: owns the PC register and the BOOT/FETCH/HOLD
// handshake with instruction memory, and flags IF/ID flushes on redirects.
module pc_fetch_sequencer
  import pc_fetch_sequencer_pkg::*;
#(
  parameter int unsigned  N          = 32,
  parameter int unsigned  ADDR_BITS  = ADDR_BITS_DEF,
  parameter logic [N-1:0] RESET_PC   = N'(RESET_PC_DEF),
  parameter logic [N-1:0] EXC_VECTOR = N'(EXC_VECTOR_DEF)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_stall_w,
  input  logic         i_branch_taken_w,
  input  logic [N-1:0] i_branch_target_dw,
  input  logic         i_jump_w,
  input  logic [N-1:0] i_jump_target_dw,
  input  logic         i_exception_w,
  input  logic         i_imem_ack_w,
  output logic         o_imem_req_w,
  output logic [N-1:0] o_pc_dw,
  output logic [N-1:0] o_pc_plus4_dw,
  output logic         o_fetch_valid_w,
  output logic         o_flush_w
);

  localparam logic [N-1:0] RESET_PC_MASKED = N'(pc_mask(PC_MAX_W'(RESET_PC), ADDR_BITS));

  fetch_state_t state, state_next;
  logic [N-1:0] pc, pc_next, pc_plus4;
  logic         flush;
  logic         redirect;
  logic         req;
  logic         fetch_valid;

  pc_next_mux #(
    .N          (N),
    .ADDR_BITS  (ADDR_BITS),
    .EXC_VECTOR (EXC_VECTOR)
  ) u_pc_next_mux (
    .state         (state),
    .pc            (pc),
    .advance       (fetch_valid),
    .exception     (i_exception_w),
    .branch_taken  (i_branch_taken_w),
    .branch_target (i_branch_target_dw),
    .jump          (i_jump_w),
    .jump_target   (i_jump_target_dw),
    .pc_next       (pc_next),
    .pc_plus4      (pc_plus4),
    .redirect      (redirect)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= BOOT;
      pc    <= RESET_PC_MASKED;
      flush <= 1'b0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      flush <= redirect;
    end
  end

  // A redirect squashes the word currently on the bus, so fetch_valid stays low.
  always_comb begin
    state_next  = state;
    req         = 1'b0;
    fetch_valid = 1'b0;
    unique case (state)
      BOOT: begin
        state_next = FETCH;
      end
      FETCH: begin
        req = 1'b1;
        if (redirect) begin
          state_next = FETCH;
        end else if (i_imem_ack_w && !i_stall_w) begin
          fetch_valid = 1'b1;
        end else if (i_imem_ack_w) begin
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (redirect) begin
          state_next = FETCH;
        end else if (!i_stall_w) begin
          fetch_valid = 1'b1;
          state_next  = FETCH;
        end
      end
      default: begin
        state_next = BOOT;
      end
    endcase
  end

  assign o_imem_req_w    = req;
  assign o_pc_dw         = pc;
  assign o_pc_plus4_dw   = pc_plus4;
  assign o_fetch_valid_w = fetch_valid;
  assign o_flush_w       = flush;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed bench for pc_fetch_sequencer: the driver queues hand-computed
// per-cycle expectations and a negedge monitor compares them against the DUT.
module tb_pc_fetch_sequencer;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic        req;
    logic        valid;
    logic        flush;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        exception;
  logic        ack;
  logic        req;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_valid;
  logic        flush;

  exp_t sb[$];
  int   tests_run = 0;
  int   tests_failed = 0;

  pc_fetch_sequencer dut (
    .clk                (clk),
    .reset              (reset),
    .i_stall_w          (stall),
    .i_branch_taken_w   (branch_taken),
    .i_branch_target_dw (branch_target),
    .i_jump_w           (jump),
    .i_jump_target_dw   (jump_target),
    .i_exception_w      (exception),
    .i_imem_ack_w       (ack),
    .o_imem_req_w       (req),
    .o_pc_dw            (pc),
    .o_pc_plus4_dw      (pc_plus4),
    .o_fetch_valid_w    (fetch_valid),
    .o_flush_w          (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check32(input string name, input string field,
                         input logic [31:0] got, input logic [31:0] want);
    tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("FAIL %s %s got %h expected %h", name, field, got, want);
    end
  endtask

  // Monitor: every cycle with a queued expectation is compared mid-cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      logic [31:0] want_plus4;
      e = sb.pop_front();
      want_plus4 = (e.pc + 32'd4) & 32'h000F_FFFC;
      check32(e.name, "pc",          pc,                   e.pc);
      check32(e.name, "pc_plus4",    pc_plus4,             want_plus4);
      check32(e.name, "req",         {31'd0, req},         {31'd0, e.req});
      check32(e.name, "fetch_valid", {31'd0, fetch_valid}, {31'd0, e.valid});
      check32(e.name, "flush",       {31'd0, flush},       {31'd0, e.flush});
    end
  end

  task automatic step(input string name,
                      input logic st, input logic ak, input logic ex,
                      input logic br, input logic [31:0] bt,
                      input logic jp, input logic [31:0] jt,
                      input logic [31:0] epc, input logic ereq,
                      input logic evalid, input logic eflush);
    exp_t e;
    stall         = st;
    ack           = ak;
    exception     = ex;
    branch_taken  = br;
    branch_target = bt;
    jump          = jp;
    jump_target   = jt;
    e.name  = name;
    e.pc    = epc;
    e.req   = ereq;
    e.valid = evalid;
    e.flush = eflush;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    stall = 1'b0; ack = 1'b0; exception = 1'b0;
    branch_taken = 1'b0; branch_target = '0;
    jump = 1'b0; jump_target = '0;
    @(posedge clk);
    #1;
    //    name              st ak ex br bt            jp jt            pc            req v  fl
    step("rst_hold",        0, 1, 0, 0, 32'h0,        0, 32'h0,        32'h0000_0000, 0, 0, 0);
    reset = 1'b1;
    step("boot",            0, 1, 0, 0, 32'h0,        0, 32'h0,        32'h0000_0000, 0, 0, 0);
    step("seq0",            0, 1, 0, 0, 32'h0,        0, 32'h0,        32'h0000_0000, 1, 1, 0);
    step("seq1",            0, 1, 0, 0, 32'h0,        0, 32'h0,        32'h0000_0004, 1, 1, 0);
    step("seq2",            0, 1, 0, 0, 32'h0,        0, 32'h0,        32'h0000_0008, 1, 1, 0);
    step("seq3",            0, 1, 0, 0, 32'h0,        0, 32'h0,        32'h0000_000C, 1, 1, 0);
    step("br_redirect",     0, 1, 0, 1, 32'h0000_1003, 0, 32'h0,       32'h0000_0010, 1, 0, 0);
    step("br_target",       0, 1, 0, 0, 32'h0,        0, 32'h0,        32'h0000_1000, 1, 1, 1);
    step("br_next",         0, 1, 0, 0, 32'h0,        0, 32'h0,        32'h0000_1004, 1, 1, 0);
    step("exc_priority",    0, 1, 1, 1, 32'h0000_2000, 1, 32'h0000_3000, 32'h0000_1008, 1, 0, 0);
    step("exc_target",      0, 0, 0, 0, 32'h0,        1, 32'hFFF4_0010, 32'h0000_0180, 1, 0, 1);
    step("jmp_masked",      0, 0, 0, 0, 32'h0,        0, 32'h0,        32'h0004_0010, 1, 0, 1);
    step("stall_ack",       1, 1, 0, 0, 32'h0,        0, 32'h0,        32'h0004_0010, 1, 0, 0);
    step("hold1",           1, 0, 0, 0, 32'h0,        0, 32'h0,        32'h0004_0010, 0, 0, 0);
    step("hold2",           1, 0, 0, 0, 32'h0,        0, 32'h0,        32'h0004_0010, 0, 0, 0);
    step("hold_release",    0, 0, 0, 0, 32'h0,        0, 32'h0,        32'h0004_0010, 0, 1, 0);
    step("stall_noack1",    1, 0, 0, 0, 32'h0,        0, 32'h0,        32'h0004_0014, 1, 0, 0);
    step("stall_noack2",    1, 0, 0, 0, 32'h0,        0, 32'h0,        32'h0004_0014, 1, 0, 0);
    step("br_over_stall",   1, 1, 0, 1, 32'h000F_FFFC, 0, 32'h0,       32'h0004_0014, 1, 0, 0);
    step("wrap_fetch",      0, 1, 0, 0, 32'h0,        0, 32'h0,        32'h000F_FFFC, 1, 1, 1);
    step("wrapped",         0, 0, 0, 0, 32'h0,        0, 32'h0,        32'h0000_0000, 1, 0, 0);
    step("hold_enter",      1, 1, 0, 0, 32'h0,        0, 32'h0,        32'h0000_0000, 1, 0, 0);
    step("hold_jump",       1, 0, 0, 0, 32'h0,        1, 32'h0000_0020, 32'h0000_0000, 0, 0, 0);
    step("jmp_from_hold",   0, 1, 0, 0, 32'h0,        0, 32'h0,        32'h0000_0020, 1, 1, 1);
    step("ack_pending",     0, 0, 0, 0, 32'h0,        0, 32'h0,        32'h0000_0024, 1, 0, 0);
    reset = 1'b0;
    step("async_reset",     0, 1, 0, 0, 32'h0,        0, 32'h0,        32'h0000_0000, 0, 0, 0);
    reset = 1'b1;
    step("boot_ignores",    0, 1, 1, 1, 32'h0000_5000, 1, 32'h0000_6000, 32'h0000_0000, 0, 0, 0);
    step("after_boot",      0, 1, 0, 0, 32'h0,        0, 32'h0,        32'h0000_0000, 1, 1, 0);
    step("final",           0, 0, 0, 0, 32'h0,        0, 32'h0,        32'h0000_0004, 1, 0, 0);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("FAIL drain pending %0d expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
